// File: rtl/bft_stream_packetizer.sv
// Leaf BFT link transmitter: turns a valid/ack word stream into addressed
// BFT packets, throttled by credits returned from the remote input port.
module bft_stream_packetizer #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int SELF_LEAF     = 1,
  parameter int CREDIT_PORT   = 0,
  parameter int LEN_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  input  logic [LEN_BITS-1:0]      burst_len,
  input  logic [PAYLOAD_BITS-1:0]  din,
  input  logic                     din_vld,
  output logic                     din_ack,
  output logic [PACKET_BITS-1:0]   dout_bft,
  input  logic [PACKET_BITS-1:0]   din_bft,
  input  logic                     resend,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               credit,
  output logic                     credit_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEPTH = 1 << NUM_ADDR_BITS;
  localparam logic [7:0] CREDIT_MAX = 8'(DEPTH);
  localparam int LEAF_HI = PACKET_BITS - 2;
  localparam int PORT_HI = LEAF_HI - NUM_LEAF_BITS;

  logic [1:0]               state;
  logic [NUM_LEAF_BITS-1:0] leaf_q;
  logic [NUM_PORT_BITS-1:0] port_q;
  logic [LEN_BITS-1:0]      len_q;
  logic [LEN_BITS-1:0]      cnt_q;
  logic [NUM_ADDR_BITS-1:0] addr_q;
  logic [7:0]               credit_q;
  logic [PACKET_BITS-1:0]   pkt_q;
  logic                     err_q;

  logic                     ack;
  logic                     is_ret;
  logic [7:0]               ret_n;
  logic [9:0]               credit_sum;
  logic                     over;
  logic [LEN_BITS-1:0]      cnt_inc;

  assign ack = (state == RUN) & din_vld
             & (credit_q != 8'd0) & ~resend;

  assign is_ret = din_bft[PACKET_BITS-1]
    & (din_bft[LEAF_HI -: NUM_LEAF_BITS]
       == NUM_LEAF_BITS'(SELF_LEAF))
    & (din_bft[PORT_HI -: NUM_PORT_BITS]
       == NUM_PORT_BITS'(CREDIT_PORT));

  assign ret_n = is_ret ? din_bft[7:0] : 8'd0;

  // ack implies credit_q != 0, so the subtraction never underflows
  assign credit_sum = {2'b0, credit_q} - {9'b0, ack}
                    + {2'b0, ret_n};
  assign over    = credit_sum > 10'(DEPTH);
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      leaf_q   <= '0;
      port_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      credit_q <= CREDIT_MAX;
      pkt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      pkt_q <= ack ? {1'b1, leaf_q, port_q, addr_q, din}
                   : '0;
      credit_q <= over ? CREDIT_MAX : credit_sum[7:0];
      if (over)
        err_q <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            leaf_q <= dest_leaf;
            port_q <= dest_port;
            len_q  <= burst_len;
            cnt_q  <= '0;
            state  <= (burst_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (ack) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_inc;
            if (cnt_inc == len_q)
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // a packet registered as resend rises is dropped; the receiver recovers it
  assign dout_bft   = resend ? '0 : pkt_q;
  assign din_ack    = ack;
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign credit     = credit_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_bft_stream_packetizer.sv
// Bench for bft_stream_packetizer: cycle model plus packet scoreboard,
// with directed scenarios for credit, resend, zero-length and reset.
module tb_bft_stream_packetizer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  dest_leaf = '0;
  logic [3:0]  dest_port = '0;
  logic [15:0] burst_len = '0;
  logic [31:0] din = '0;
  logic        din_vld = 1'b0;
  logic        din_ack;
  logic [48:0] dout_bft;
  logic [48:0] din_bft = '0;
  logic        resend = 1'b0;
  logic        busy;
  logic        done;
  logic [7:0]  credit;
  logic        credit_err;

  always #5 clk = ~clk;

  bft_stream_packetizer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .dest_leaf  (dest_leaf),
    .dest_port  (dest_port),
    .burst_len  (burst_len),
    .din        (din),
    .din_vld    (din_vld),
    .din_ack    (din_ack),
    .dout_bft   (dout_bft),
    .din_bft    (din_bft),
    .resend     (resend),
    .busy       (busy),
    .done       (done),
    .credit     (credit),
    .credit_err (credit_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          m_state;
  logic [4:0]  m_leaf;
  logic [3:0]  m_port;
  int          m_len;
  int          m_cnt;
  int          m_addr;
  int          m_credit;
  bit          m_err;
  bit          m_pend;
  bit          last_ack;
  logic [48:0] sb[$];

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [48:0] pkt(logic [4:0] l,
                                      logic [3:0] p,
                                      logic [7:0] n);
    return {1'b1, l, p, 7'd0, 24'd0, n};
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_leaf   = '0;
    m_port   = '0;
    m_len    = 0;
    m_cnt    = 0;
    m_addr   = 0;
    m_credit = 128;
    m_err    = 0;
    m_pend   = 0;
    last_ack = 0;
    sb.delete();
  endtask

  // called just after a negedge with inputs applied
  task automatic step();
    logic [48:0] exp_pkt;
    bit ack;
    int n;
    #1;
    ack = (m_state == 1) && din_vld
       && (m_credit != 0) && !resend;
    exp_pkt = '0;
    if (m_pend) begin
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else exp_pkt = sb.pop_front();
    end
    if (resend) exp_pkt = '0;
    check("dout", dout_bft, exp_pkt);
    check("ack", din_ack, ack);
    check("busy", busy, m_state == 1);
    check("done", done, m_state == 2);
    check("credit", credit, m_credit);
    check("err", credit_err, m_err);
    n = 0;
    if (din_bft[48] && din_bft[47:43] == 5'd1
        && din_bft[42:39] == 4'd0)
      n = int'(din_bft[7:0]);
    m_credit = m_credit - int'(ack) + n;
    if (m_credit > 128) begin
      m_credit = 128;
      m_err = 1;
    end
    if (ack)
      sb.push_back({1'b1, m_leaf, m_port,
                    7'(m_addr), din});
    m_pend = ack;
    last_ack = ack;
    case (m_state)
      0: if (start) begin
        m_leaf  = dest_leaf;
        m_port  = dest_port;
        m_len   = int'(burst_len);
        m_cnt   = 0;
        m_state = (burst_len == 0) ? 2 : 1;
      end
      1: if (ack) begin
        m_addr = (m_addr + 1) % 128;
        m_cnt++;
        if (m_cnt == m_len) m_state = 2;
      end
      default: m_state = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic tick();
    step();
    if (last_ack) din = din + 1;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_dout", dout_bft, 0);
    check("rst_ack", din_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_credit", credit, 128);
    check("rst_err", credit_err, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic start_burst(logic [4:0] l, logic [3:0] p,
                             logic [15:0] len);
    start = 1'b1;
    dest_leaf = l;
    dest_port = p;
    burst_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(int budget);
    int k = 0;
    while (m_state != 2 && k < budget) begin
      tick();
      k++;
    end
    if (m_state != 2) check("timeout_done", 0, 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // basic four-word burst
    din = 32'hA0;
    din_vld = 1'b1;
    start_burst(5'd3, 4'd2, 16'd4);
    run_to_done(20);
    #1;
    check("t1_done", done, 1);
    check("t1_last", dout_bft,
          {1'b1, 5'd3, 4'd2, 7'd3, 32'hA3});
    check("t1_credit", credit, 124);
    tick();
    din_vld = 1'b0;
    tick();

    // credit exhaustion and address wrap
    do_reset();
    din = 32'hB000_0000;
    din_vld = 1'b1;
    start_burst(5'd7, 4'd5, 16'd130);
    for (int k = 0; k < 200 && m_credit != 0; k++) tick();
    repeat (3) tick();
    #1;
    check("t2_stall_ack", din_ack, 0);
    check("t2_stall_dout", dout_bft, 0);
    din_bft = pkt(5'd1, 4'd0, 8'd8);
    tick();
    din_bft = '0;
    run_to_done(20);
    #1;
    check("t2_addr130", dout_bft[38:32], 1);
    check("t2_data130", dout_bft[31:0], 32'hB000_0081);
    tick();

    // credit arithmetic and overflow
    do_reset();
    din = 32'hC000_0000;
    din_vld = 1'b1;
    start_burst(5'd4, 4'd1, 16'd200);
    for (int k = 0; k < 200 && m_credit != 10; k++) tick();
    din_bft = pkt(5'd1, 4'd0, 8'd5);
    tick();
    din_bft = '0;
    din_vld = 1'b0;
    #1;
    check("t3_credit14", credit, 14);
    din_bft = pkt(5'd2, 4'd0, 8'd50);
    tick();
    din_bft = pkt(5'd1, 4'd3, 8'd50);
    tick();
    din_bft = pkt(5'd1, 4'd0, 8'd112);
    tick();
    din_bft = pkt(5'd1, 4'd0, 8'd5);
    #1;
    check("t3_credit126", credit, 126);
    tick();
    din_bft = '0;
    #1;
    check("t3_sat", credit, 128);
    check("t3_err", credit_err, 1);

    // resend freezes the stream mid-burst
    din_vld = 1'b1;
    tick();
    tick();
    resend = 1'b1;
    repeat (3) begin
      #1;
      check("t4_rs_dout", dout_bft, 0);
      check("t4_rs_ack", din_ack, 0);
      tick();
    end
    resend = 1'b0;
    run_to_done(200);
    tick();

    // start while running is ignored
    din = 32'hD0;
    start_burst(5'd6, 4'd6, 16'd3);
    tick();
    start = 1'b1;
    dest_leaf = 5'd9;
    dest_port = 4'd9;
    burst_len = 16'd50;
    tick();
    start = 1'b0;
    run_to_done(10);
    #1;
    check("t5_leaf", dout_bft[47:43], 6);
    tick();

    // zero-length burst
    start_burst(5'd2, 4'd2, 16'd0);
    #1;
    check("t6_done", done, 1);
    check("t6_dout", dout_bft, 0);
    tick();
    tick();

    // reset in the middle of a burst
    start_burst(5'd3, 4'd3, 16'd10);
    repeat (3) tick();
    do_reset();
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
